// File: rtl/bell_judge.sv
`default_nettype none
// ============================================================================
// Module   : bell_judge
// Brief    : Holds both players' top cards and the per-colour fruit totals,
//            judges bell presses against TARGET, keeps both scores, and ends
//            the game at WIN_SCORE. Optional wrong-press penalty is enabled
//            with the macro BELL_JUDGE_PENALTY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bell_judge #(
    parameter int TARGET    = 5,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 7,
    parameter int LOCK_CYC  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               card_vld,
    input  logic               card_owner,
    input  logic [1:0]         card_color,
    input  logic [2:0]         card_num,
    input  logic               bell1,
    input  logic               bell2,
    output logic [1:0]         top1_color,
    output logic [2:0]         top1_num,
    output logic [1:0]         top2_color,
    output logic [2:0]         top2_num,
    output logic [3:0]         sum_a,
    output logic [3:0]         sum_b,
    output logic [3:0]         sum_c,
    output logic               match,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               result_vld,
    output logic               result_win,
    output logic               result_who,
    output logic               game_over,
    output logic               winner,
    output logic               finish
);

    localparam int                 c_lock_w    = $clog2(LOCK_CYC + 1);
    localparam logic [c_lock_w-1:0] c_lock_init = c_lock_w'(LOCK_CYC);
    localparam logic [c_lock_w-1:0] c_lock_one  = c_lock_w'(1);
    localparam logic [3:0]          c_target    = 4'(TARGET);
    localparam logic [SCORE_W-1:0]  c_win_score = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0]  c_score_one = SCORE_W'(1);

    typedef enum logic [1:0] {
        S_PLAY    = 2'd0,
        S_RESOLVE = 2'd1,
        S_LOCK    = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_bell1_q;
    logic                 r_bell2_q;
    logic [1:0]           r_top1_color;
    logic [2:0]           r_top1_num;
    logic [1:0]           r_top2_color;
    logic [2:0]           r_top2_num;
    logic [3:0]           r_sum_a;
    logic [3:0]           r_sum_b;
    logic [3:0]           r_sum_c;
    logic                 r_match;
    logic [SCORE_W-1:0]   r_score1;
    logic [SCORE_W-1:0]   r_score2;
    logic                 r_who;
    logic                 r_snap;
    logic [c_lock_w-1:0]  r_lock_cnt;
    logic                 r_finish;

    logic                 w_edge1;
    logic                 w_edge2;
    logic                 w_press;
    logic [SCORE_W-1:0]   w_presser_score;
    logic [SCORE_W-1:0]   w_new_score;
    logic [3:0]           w_sum_a;
    logic [3:0]           w_sum_b;
    logic [3:0]           w_sum_c;

    function automatic logic [3:0] f_contrib(input logic [1:0] col,
                                             input logic [2:0] num,
                                             input logic [1:0] sel);
        return (col == sel) ? {1'b0, num} : 4'd0;
    endfunction

    assign w_edge1 = bell1 & ~r_bell1_q;
    assign w_edge2 = bell2 & ~r_bell2_q;
    assign w_press = (r_state == S_PLAY) & (w_edge1 | w_edge2);

    assign w_sum_a = f_contrib(r_top1_color, r_top1_num, 2'b01) + f_contrib(r_top2_color, r_top2_num, 2'b01);
    assign w_sum_b = f_contrib(r_top1_color, r_top1_num, 2'b10) + f_contrib(r_top2_color, r_top2_num, 2'b10);
    assign w_sum_c = f_contrib(r_top1_color, r_top1_num, 2'b11) + f_contrib(r_top2_color, r_top2_num, 2'b11);

    assign w_presser_score = r_who ? r_score2 : r_score1;

    always_comb begin
        w_new_score = w_presser_score;
        if (r_snap) begin
            w_new_score = w_presser_score + c_score_one;
        end else begin
`ifdef BELL_JUDGE_PENALTY_EN
            if (w_presser_score != '0) begin
                w_new_score = w_presser_score - c_score_one;
            end
`else
            w_new_score = w_presser_score;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PLAY:    if (w_press) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = (w_new_score == c_win_score) ? S_OVER : S_LOCK;
            S_LOCK:    if (r_lock_cnt == c_lock_one) w_state_nxt = S_PLAY;
            S_OVER:    w_state_nxt = S_OVER;
            default:   w_state_nxt = S_PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_PLAY;
            r_bell1_q    <= 1'b1;
            r_bell2_q    <= 1'b1;
            r_top1_color <= 2'b00;
            r_top1_num   <= 3'd0;
            r_top2_color <= 2'b00;
            r_top2_num   <= 3'd0;
            r_sum_a      <= 4'd0;
            r_sum_b      <= 4'd0;
            r_sum_c      <= 4'd0;
            r_match      <= 1'b0;
            r_score1     <= '0;
            r_score2     <= '0;
            r_who        <= 1'b0;
            r_snap       <= 1'b0;
            r_lock_cnt   <= '0;
            r_finish     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bell1_q <= bell1;
            r_bell2_q <= bell2;
            r_finish  <= (r_state == S_RESOLVE) && (w_state_nxt == S_OVER);

            // Player 1 takes priority on simultaneous edges.
            if (w_press) begin
                r_who  <= ~w_edge1;
                r_snap <= r_match;
            end

            if (r_state == S_RESOLVE) begin
                r_lock_cnt <= c_lock_init;
            end else if (r_state == S_LOCK) begin
                r_lock_cnt <= r_lock_cnt - c_lock_one;
            end

            if (r_state == S_RESOLVE) begin
                if (r_who) r_score2 <= w_new_score;
                else       r_score1 <= w_new_score;
            end

            // A card arriving in the resolve cycle overrides the clear for its owner.
            if ((r_state == S_RESOLVE) && r_snap) begin
                r_top1_color <= 2'b00;
                r_top1_num   <= 3'd0;
                r_top2_color <= 2'b00;
                r_top2_num   <= 3'd0;
            end
            if (card_vld && (r_state != S_OVER)) begin
                if (card_owner) begin
                    r_top2_color <= card_color;
                    r_top2_num   <= card_num;
                end else begin
                    r_top1_color <= card_color;
                    r_top1_num   <= card_num;
                end
            end

            r_sum_a <= w_sum_a;
            r_sum_b <= w_sum_b;
            r_sum_c <= w_sum_c;
            r_match <= (w_sum_a == c_target) | (w_sum_b == c_target) | (w_sum_c == c_target);
        end
    end

    assign top1_color = r_top1_color;
    assign top1_num   = r_top1_num;
    assign top2_color = r_top2_color;
    assign top2_num   = r_top2_num;
    assign sum_a      = r_sum_a;
    assign sum_b      = r_sum_b;
    assign sum_c      = r_sum_c;
    assign match      = r_match;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign result_vld = (r_state == S_RESOLVE);
    assign result_win = result_vld & r_snap;
    assign result_who = result_vld & r_who;
    assign game_over  = (r_state == S_OVER);
    assign winner     = game_over & r_who;
    assign finish     = r_finish;

endmodule
`default_nettype wire
